// File: rtl/load_store_unit_if.sv
// ============================================================================
// Module   : load_store_unit_if
// Brief    : Pipeline request/response and data-memory bus of the load/store unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface load_store_unit_if;
  logic        req_valid_in;
  logic        req_ready_out;
  logic        req_is_store_in;
  logic [1:0]  req_size_in;
  logic        req_signed_in;
  logic [31:0] req_addr_in;
  logic [31:0] req_wdata_in;
  logic        resp_valid_out;
  logic [31:0] resp_rdata_out;
  logic        resp_misaligned_out;
  logic [31:0] mem_addr_out;
  logic [31:0] mem_writedata_out;
  logic        mem_re_out;
  logic        mem_we_out;
  logic [1:0]  mem_size_out;
  logic [31:0] mem_readdata_in;

  modport slave (
    input  req_valid_in, req_is_store_in, req_size_in, req_signed_in,
    input  req_addr_in, req_wdata_in, mem_readdata_in,
    output req_ready_out, resp_valid_out, resp_rdata_out, resp_misaligned_out,
    output mem_addr_out, mem_writedata_out, mem_re_out, mem_we_out, mem_size_out
  );

  modport master (
    output req_valid_in, req_is_store_in, req_size_in, req_signed_in,
    output req_addr_in, req_wdata_in, mem_readdata_in,
    input  req_ready_out, resp_valid_out, resp_rdata_out, resp_misaligned_out,
    input  mem_addr_out, mem_writedata_out, mem_re_out, mem_we_out, mem_size_out
  );
endinterface

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module   : load_store_unit
// Brief    : Big-endian byte/halfword/word load-store unit with read-modify-write sub-word stores.
// Revision : 1.0
// ============================================================================
`default_nettype none

module load_store_unit (
  input  logic               clock,
  input  logic               reset,
  load_store_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    MERGE  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        is_store_q, is_store_d;
  logic        signed_q, signed_d;
  logic        misaligned_q, misaligned_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;

  logic        req_misaligned;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_data;
  logic [31:0] merged_data;
  logic [31:0] word_addr;

  logic        ready_o, resp_valid_o, resp_mis_o, re_o, we_o;
  logic [31:0] resp_rdata_o, mem_addr_o, mem_wdata_o;

  always_comb begin
    req_misaligned = 1'b0;
    case (bus.req_size_in)
      2'b01:   req_misaligned = bus.req_addr_in[0];
      2'b11:   req_misaligned = (bus.req_addr_in[1:0] != 2'b00);
      2'b10:   req_misaligned = 1'b1;
      default: req_misaligned = 1'b0;
    endcase
  end

  assign word_addr = {addr_q[31:2], 2'b00};

  // Lane 0 is the most significant byte of the word (big-endian).
  always_comb begin
    byte_lane   = 8'h00;
    half_lane   = 16'h0000;
    merged_data = word_q;
    case (addr_q[1:0])
      2'd0: begin byte_lane = word_q[31:24]; end
      2'd1: begin byte_lane = word_q[23:16]; end
      2'd2: begin byte_lane = word_q[15:8];  end
      default: begin byte_lane = word_q[7:0]; end
    endcase
    half_lane = addr_q[1] ? word_q[15:0] : word_q[31:16];
    if (size_q == 2'b00) begin
      case (addr_q[1:0])
        2'd0:    merged_data[31:24] = wdata_q[7:0];
        2'd1:    merged_data[23:16] = wdata_q[7:0];
        2'd2:    merged_data[15:8]  = wdata_q[7:0];
        default: merged_data[7:0]   = wdata_q[7:0];
      endcase
    end else if (size_q == 2'b01) begin
      if (addr_q[1]) merged_data[15:0]  = wdata_q[15:0];
      else           merged_data[31:16] = wdata_q[15:0];
    end else begin
      merged_data = wdata_q;
    end
  end

  always_comb begin
    load_data = word_q;
    case (size_q)
      2'b00:   load_data = {{24{signed_q & byte_lane[7]}}, byte_lane};
      2'b01:   load_data = {{16{signed_q & half_lane[15]}}, half_lane};
      default: load_data = word_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    is_store_d   = is_store_q;
    signed_d     = signed_q;
    misaligned_d = misaligned_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    word_d       = word_q;
    ready_o      = 1'b0;
    resp_valid_o = 1'b0;
    resp_mis_o   = 1'b0;
    resp_rdata_o = 32'h0;
    re_o         = 1'b0;
    we_o         = 1'b0;
    mem_addr_o   = 32'h0;
    mem_wdata_o  = 32'h0;

    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (bus.req_valid_in) begin
          is_store_d   = bus.req_is_store_in;
          signed_d     = bus.req_signed_in;
          size_d       = bus.req_size_in;
          addr_d       = bus.req_addr_in;
          wdata_d      = bus.req_wdata_in;
          misaligned_d = req_misaligned;
          state_d      = req_misaligned ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        mem_addr_o = word_addr;
        if (is_store_q && (size_q == 2'b11)) begin
          we_o        = 1'b1;
          mem_wdata_o = wdata_q;
          state_d     = DONE;
        end else begin
          // Sub-word stores read the word first so the untouched lanes survive.
          re_o    = 1'b1;
          word_d  = bus.mem_readdata_in;
          state_d = is_store_q ? MERGE : DONE;
        end
      end
      MERGE: begin
        mem_addr_o  = word_addr;
        we_o        = 1'b1;
        mem_wdata_o = merged_data;
        state_d     = DONE;
      end
      default: begin
        resp_valid_o = 1'b1;
        resp_mis_o   = misaligned_q;
        resp_rdata_o = (!is_store_q && !misaligned_q) ? load_data : 32'h0;
        state_d      = IDLE;
      end
    endcase

    // Outputs are forced quiet while reset is held, before the state register clears.
    if (!reset) begin
      ready_o      = 1'b0;
      resp_valid_o = 1'b0;
      resp_mis_o   = 1'b0;
      resp_rdata_o = 32'h0;
      re_o         = 1'b0;
      we_o         = 1'b0;
      mem_addr_o   = 32'h0;
      mem_wdata_o  = 32'h0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      is_store_q   <= 1'b0;
      signed_q     <= 1'b0;
      misaligned_q <= 1'b0;
      size_q       <= 2'b00;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      word_q       <= 32'h0;
    end else begin
      state_q      <= state_d;
      is_store_q   <= is_store_d;
      signed_q     <= signed_d;
      misaligned_q <= misaligned_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      word_q       <= word_d;
    end
  end

  assign bus.req_ready_out       = ready_o;
  assign bus.resp_valid_out      = resp_valid_o;
  assign bus.resp_misaligned_out = resp_mis_o;
  assign bus.resp_rdata_out      = resp_rdata_o;
  assign bus.mem_re_out          = re_o;
  assign bus.mem_we_out          = we_o;
  assign bus.mem_addr_out        = mem_addr_o;
  assign bus.mem_writedata_out   = mem_wdata_o;
  assign bus.mem_size_out        = 2'b11;

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have these ports, clock and reset first:
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- req_valid_in  in  1  pipeline memory request present
- req_ready_out  out  1  unit can accept a request
- req_is_store_in  in  1  1 = store, 0 = load
- req_size_in  in  2  00 byte, 01 halfword, 11 word, 10 reserved
- req_signed_in  in  1  sign-extend sub-word loads
- req_addr_in  in  32  byte address
- req_wdata_in  in  32  store data, right-justified
- resp_valid_out  out  1  one-cycle completion pulse
- resp_rdata_out  out  32  load result; 0 for stores and errors
- resp_misaligned_out  out  1  request faulted; qualified by resp_valid_out
- mem_addr_out  out  32  word address to data memory
- mem_writedata_out  out  32  full-word write data
- mem_re_out  out  1  memory read enable
- mem_we_out  out  1  memory write enable
- mem_size_out  out  2  constant 2'b11
- mem_readdata_in  in  32  combinational word read data from memory

REQ-002 SHALL have no parameters.

Function
REQ-003 SHALL implement a state machine with states IDLE, ACCESS, MERGE and DONE.
REQ-004 SHALL assert req_ready_out only in IDLE; a request is accepted on an edge where req_valid_in and req_ready_out are both 1.
REQ-005 SHALL register is_store, size, signed, addr and wdata at acceptance; request inputs are ignored outside IDLE.
REQ-006 SHALL flag a request misaligned when any of these holds:
- size 01 with addr[0] = 1
- size 11 with addr[1:0] not 00
- size 10 (reserved)
REQ-007 SHALL send a misaligned request IDLE -> DONE with no memory access; resp_misaligned_out = 1 and resp_rdata_out = 0.
REQ-008 SHALL send an aligned request IDLE -> ACCESS.
REQ-009 SHALL in ACCESS drive mem_addr_out = {addr[31:2], 2'b00} and mem_size_out = 2'b11.
REQ-010 SHALL in ACCESS assert mem_re_out for a load or a sub-word store, capturing mem_readdata_in into a word register at the end of the cycle.
REQ-011 SHALL in ACCESS assert mem_we_out with mem_writedata_out = wdata for a word store, then go to DONE.
REQ-012 SHALL go ACCESS -> MERGE for a sub-word store; MERGE asserts mem_we_out for exactly one cycle at the same address, with merged data, then goes to DONE.
REQ-013 SHALL use big-endian lanes:
- byte: addr[1:0] = 0 selects bits [31:24], 3 selects [7:0]
- halfword: addr[1] = 0 selects [31:16], 1 selects [15:0]
REQ-014 SHALL form merged store data by replacing only the selected lane with the low byte or halfword of wdata; other lanes come from the captured word.
REQ-015 SHALL form the load result by extracting the selected lane, zero-extended, or sign-extended when signed = 1; word loads return the captured word unchanged.
REQ-016 SHALL in DONE assert resp_valid_out for exactly one cycle, then return to IDLE; there is no response backpressure.
REQ-017 SHALL deassert mem_re_out and mem_we_out in IDLE and DONE, and drive mem_addr_out and mem_writedata_out to 0 there.
REQ-018 SHALL meet these latencies from the acceptance edge to resp_valid_out high:
- misaligned: 1 cycle
- load or word store: 2 cycles
- sub-word store: 3 cycles
REQ-019 SHALL never assert mem_re_out and mem_we_out in the same cycle.

Reset
REQ-020 SHALL, while reset = 0 at an edge, enter IDLE and clear all registered request and data state.
REQ-021 SHALL gate mem_we_out and mem_re_out low combinationally whenever reset = 0, so an in-flight operation issues no write during reset.
REQ-022 SHALL drive these values during and after reset: req_ready_out = 1 once reset = 1; resp_valid_out, resp_misaligned_out = 0; resp_rdata_out, mem_addr_out, mem_writedata_out = 0.

Verification
REQ-023 Signed byte load: memory word at 0x10000004 = 0x8899AABB; load byte, signed, at 0x10000005 -> mem_re_out one cycle at 0x10000004; resp_rdata_out = 0xFFFFFF99 two cycles after acceptance.
REQ-024 Unsigned halfword load: same word; load halfword, unsigned, at 0x10000006 -> resp_rdata_out = 0x0000AABB, resp_misaligned_out = 0.
REQ-025 Byte store: same word; store byte at 0x10000007 with wdata 0x12345611 -> one read cycle, then one mem_we_out cycle with data 0x8899AA11; resp_valid_out 3 cycles after acceptance.
REQ-026 Misaligned store: store word at 0x10000002 -> mem_we_out and mem_re_out never asserted; resp_valid_out and resp_misaligned_out high 1 cycle after acceptance; next request accepted immediately after.
REQ-027 Reset during RMW: reset = 0 in the MERGE cycle of a byte store -> no mem_we_out pulse; no resp_valid_out; req_ready_out = 1 on the first cycle with reset = 1.
REQ-028 Back-to-back traffic: word store 0xDEADBEEF to 0x7FFFFFFC, immediately followed by a word load from the same address -> resp_rdata_out = 0xDEADBEEF; req_ready_out low throughout each operation.
